fpu_issue: RTL and testbench
============================

FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum number of RUN cycles allowed before a timeout (used only when FPU_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port req_valid  in  1  an upstream request is present.
REQ-005 SHALL have port req_ready  out  1  the block can accept a request.
REQ-006 SHALL have ports req_a, req_b  in  32 each  IEEE-754 single-precision operands.
REQ-007 SHALL have port req_op  in  2  FPU operation code (2'b00 add, 2'b01 mul), passed through unchanged.
REQ-008 SHALL have ports res_valid  out  1, res_ready  in  1, res_data  out  32, res_op  out  2 (echo of the op that produced res_data).
REQ-009 SHALL have port res_timeout  out  1  res_data came from a timeout rather than from the FPU.
REQ-010 SHALL have ports fpu_rst, fpu_start  out  1 each; fpu_a, fpu_b  out  32 each; fpu_op  out  2; driving the downstream fpu.
REQ-011 SHALL have ports fpu_r  in  32 and fpu_done  in  1  result and completion from the fpu.
REQ-012 SHALL have port busy  out  1  high when the state is not IDLE or the FIFO is non-empty.

Function
REQ-013 SHALL buffer requests in a 2-entry FIFO; req_ready = FIFO not full; a push occurs when req_valid && req_ready at a rising edge.
REQ-014 SHALL implement states IDLE, CLR, RUN, HOLD.
REQ-015 In IDLE with the FIFO non-empty: pop the head into the operand/op registers and go to CLR on the same edge.
REQ-016 In CLR: drive fpu_rst=1 for exactly one cycle, then go to RUN.
REQ-017 In RUN: drive fpu_start=1; fpu_a/fpu_b/fpu_op SHALL stay stable from CLR until HOLD.
REQ-018 In RUN, fpu_done=1 sampled at an edge: capture fpu_r into res_data and the op into res_op, set res_valid=1 and res_timeout=0, go to HOLD; fpu_start=0 from then on.
REQ-019 fpu_done SHALL be ignored in IDLE, CLR and HOLD.
REQ-020 In HOLD: res_valid, res_data, res_op and res_timeout SHALL stay stable; on res_ready=1 at an edge, clear res_valid and go to IDLE.
REQ-021 Minimum latency: request accepted at edge N into an empty, idle block → CLR at N+1 → RUN at N+2; res_valid rises at the edge after fpu_done is sampled.
REQ-022 Push and pop on the same edge SHALL both take effect; the FIFO count SHALL be unchanged.
REQ-023 Pushes SHALL continue during RUN and HOLD while the FIFO is not full; FIFO pointers wrap modulo 2.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, empty the FIFO, and drive every output to 0 (req_ready=1 once rst is released).
REQ-025 rst asserted mid-operation SHALL abort the in-flight request and discard buffered requests; no result is produced for them.

Configuration
REQ-026 Macro FPU_TIMEOUT_EN defined: a counter SHALL clear on entry to RUN and count RUN cycles; on reaching TIMEOUT_CYCLES without fpu_done, set res_data=32'h7FC00000 (quiet NaN), res_timeout=1, res_valid=1, and go to HOLD.
REQ-027 FPU_TIMEOUT_EN undefined: there SHALL be no counter, res_timeout SHALL be tied 0, and RUN SHALL wait for fpu_done indefinitely.

Verification
REQ-028 Single add: A=0x41C00000, B=0x40C00000, op=00; the model returns 0x41F00000 with done 12 cycles after start → one-cycle fpu_rst, then fpu_start; res_valid with res_data=0x41F00000, res_op=00, res_timeout=0.
REQ-029 Burst of 4 requests, res_ready=0: the first is popped, two are buffered, and req_ready=0 stalls the 4th; results emerge in order after res_ready=1.
REQ-030 Multiply 0x40561B86 × 0x3EC28F5C, model result 0x3FA2B8C2, res_ready held low for 20 cycles → res_valid and res_data stay stable and no new fpu_start occurs until the handshake completes.
REQ-031 fpu_done pulsed during CLR and during HOLD → ignored; exactly one result per request.
REQ-032 FPU_TIMEOUT_EN with TIMEOUT_CYCLES=16, model never raises done → after 16 RUN cycles res_data=0x7FC00000 and res_timeout=1; the next request then proceeds normally.
REQ-033 rst asserted in the 5th RUN cycle with 2 requests buffered → all outputs go to 0 immediately, the FIFO is empty, and no result is produced after rst is released.

Source files
------------

// File: rtl/fpu_issue_if.sv
// Request/result handshake bundle for fpu_issue: upstream request channel
// plus the result channel returned to the requester.
interface fpu_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_op;
    logic        res_timeout;

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_op, res_timeout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_op, res_timeout
    );
endinterface

// File: rtl/fpu_issue.sv
// fpu_issue: 2-entry request FIFO feeding one FPU operation at a time (IDLE/CLR/RUN/HOLD).
// Optional macro FPU_TIMEOUT_EN bounds RUN to TIMEOUT_CYCLES and returns a quiet NaN on expiry.
module fpu_issue #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    fpu_issue_if.slave  bus,
    output logic        fpu_rst,
    output logic        fpu_start,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    input  logic [31:0] fpu_r,
    input  logic        fpu_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, HOLD} state_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } req_t;

    state_t      state;
    req_t        fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_op;

    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state == IDLE) && (count != 2'd0);
    assign bus.req_ready = !rst && (count != 2'd2);
    assign busy          = (state != IDLE) || (count != 2'd0);
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_op    = res_op;

`ifdef FPU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          res_timeout;
    assign bus.res_timeout = res_timeout;
`else
    // Without the timeout build the parameter has no effect.
    logic [31:0] unused_tmo;
    assign unused_tmo      = TIMEOUT_CYCLES;
    assign bus.res_timeout = 1'b0;
`endif

    // Storage needs no reset: count/pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.req_a, bus.req_b, bus.req_op};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fpu_rst   <= 1'b0;
            fpu_start <= 1'b0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
`ifdef FPU_TIMEOUT_EN
            tmo_cnt     <= '0;
            res_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (pop) begin
                    fpu_a   <= fifo_mem[rd_ptr].a;
                    fpu_b   <= fifo_mem[rd_ptr].b;
                    fpu_op  <= fifo_mem[rd_ptr].op;
                    fpu_rst <= 1'b1;
                    state   <= CLR;
                end
                CLR: begin
                    fpu_rst   <= 1'b0;
                    fpu_start <= 1'b1;
                    state     <= RUN;
`ifdef FPU_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                RUN: begin
                    if (fpu_done) begin
                        res_data  <= fpu_r;
                        res_op    <= fpu_op;
                        res_valid <= 1'b1;
                        fpu_start <= 1'b0;
                        state     <= HOLD;
`ifdef FPU_TIMEOUT_EN
                        res_timeout <= 1'b0;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        res_data    <= 32'h7FC0_0000;
                        res_op      <= fpu_op;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b1;
                        fpu_start   <= 1'b0;
                        state       <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                HOLD: if (bus.res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with a behavioural FPU that answers a fixed
// number of cycles after fpu_start.
module tb_fpu_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fpu_rst, fpu_start, busy;
    logic [31:0] fpu_a, fpu_b;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_r = '0;
    logic        fpu_done;
    logic        mdone = 1'b0;
    logic        inj = 1'b0;
    logic        hang = 1'b0;
    logic        mfired = 1'b0;
    int          mcnt = 0;
    int          lat = 12;
    int          n_cmp = 0;
    int          n_bad = 0;

    fpu_issue_if bus ();

    fpu_issue #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fpu_rst(fpu_rst), .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_op(fpu_op), .fpu_r(fpu_r), .fpu_done(fpu_done), .busy(busy)
    );

    always #5 clk = ~clk;
    assign fpu_done = mdone | inj;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (op == 2'b00 && a == 32'h41C0_0000 && b == 32'h40C0_0000) return 32'h41F0_0000;
        if (op == 2'b01 && a == 32'h4056_1B86 && b == 32'h3EC2_8F5C) return 32'h3FA2_B8C2;
        return {a[15:0], b[15:0]};
    endfunction

    // FPU model: done pulses on the lat-th cycle after start, once per fpu_rst.
    always @(negedge clk) begin
        mdone = 1'b0;
        if (rst || fpu_rst) begin
            mcnt   = 0;
            mfired = 1'b0;
        end else if (fpu_start && !mfired && !hang) begin
            mcnt++;
            if (mcnt == lat) begin
                mdone  = 1'b1;
                mfired = 1'b1;
                fpu_r  = model(fpu_a, fpu_b, fpu_op);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int g = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        while (!bus.req_ready && g < 300) begin @(negedge clk); g++; end
        chk("send_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, output int k);
        k = 0;
        while (!bus.res_valid && k < 300) begin @(negedge clk); k++; end
        chk(tag, {31'd0, bus.res_valid}, 32'd1);
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    logic [31:0] exp_d [4] = '{32'h1111_000A, 32'h2222_000B, 32'h3333_000C, 32'h4444_000D};
    logic [1:0]  exp_o [4] = '{2'b00, 2'b01, 2'b00, 2'b01};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic ok;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_flags", {26'd0, bus.req_ready, bus.res_valid, bus.res_timeout, fpu_rst, fpu_start, busy}, 32'd0);
        chk("rst_data", bus.res_data, 32'd0);
        rst = 1'b0;
        #1 chk("rst_rel_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        // Single add, done 12 cycles after start
        lat = 12;
        send(32'h41C0_0000, 32'h40C0_0000, 2'b00);
        chk("add_busy", {31'd0, busy}, 32'd1);
        chk("add_no_clr_yet", {31'd0, fpu_rst}, 32'd0);
        @(negedge clk);
        chk("add_clr", {30'd0, fpu_rst, fpu_start}, 32'd2);
        chk("add_fpu_a", fpu_a, 32'h41C0_0000);
        chk("add_fpu_b", fpu_b, 32'h40C0_0000);
        @(negedge clk);
        chk("add_run", {30'd0, fpu_rst, fpu_start}, 32'd1);
        wait_res("add_res_valid", k);
        chk("add_latency", k, 32'd12);
        chk("add_data", bus.res_data, 32'h41F0_0000);
        chk("add_op_to", {29'd0, bus.res_op, bus.res_timeout}, 32'd0);
        chk("add_start_low", {31'd0, fpu_start}, 32'd0);
        accept();
        chk("add_after_hs", {30'd0, bus.res_valid, busy}, 32'd0);

        // Burst of four with results back-pressured
        lat = 3;
        send(32'h0000_1111, 32'h0000_000A, 2'b00);
        send(32'h0000_2222, 32'h0000_000B, 2'b01);
        send(32'h0000_3333, 32'h0000_000C, 2'b00);
        bus.req_valid = 1'b1;
        bus.req_a     = 32'h0000_4444;
        bus.req_b     = 32'h0000_000D;
        bus.req_op    = 2'b01;
        chk("burst_full", {31'd0, bus.req_ready}, 32'd0);
        wait_res("burst_first_valid", k);
        chk("burst_stall", {31'd0, bus.req_ready}, 32'd0);
        fork
            begin
                int g = 0;
                while (!bus.req_ready && g < 300) begin @(negedge clk); g++; end
                chk("burst_4th_ready", {31'd0, bus.req_ready}, 32'd1);
                @(posedge clk);
                @(negedge clk);
                bus.req_valid = 1'b0;
            end
            begin
                int kk;
                bus.res_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    wait_res($sformatf("burst_valid%0d", i), kk);
                    chk($sformatf("burst_data%0d", i), bus.res_data, exp_d[i]);
                    chk($sformatf("burst_op%0d", i), {30'd0, bus.res_op}, {30'd0, exp_o[i]});
                    @(posedge clk);
                    @(negedge clk);
                end
                bus.res_ready = 1'b0;
            end
        join
        chk("burst_idle", {31'd0, busy}, 32'd0);

        // Multiply held 20 cycles with another request waiting
        lat = 5;
        send(32'h4056_1B86, 32'h3EC2_8F5C, 2'b01);
        wait_res("mul_valid", k);
        send(32'h0000_5555, 32'h0000_0007, 2'b00);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!bus.res_valid || bus.res_data !== 32'h3FA2_B8C2 || fpu_start || fpu_rst) ok = 1'b0;
            @(negedge clk);
        end
        chk("mul_hold_stable", {31'd0, ok}, 32'd1);
        chk("mul_data", bus.res_data, 32'h3FA2_B8C2);
        chk("mul_op", {30'd0, bus.res_op}, 32'd1);
        accept();
        chk("mul_hs_clear", {31'd0, bus.res_valid}, 32'd0);
        wait_res("mul_next_valid", k);
        chk("mul_next_data", bus.res_data, 32'h5555_0007);
        accept();

        // Spurious done in CLR and HOLD
        lat = 6;
        send(32'h0000_AAAA, 32'h0000_0001, 2'b01);
        @(negedge clk);
        chk("spur_in_clr", {31'd0, fpu_rst}, 32'd1);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        wait_res("spur_valid", k);
        chk("spur_latency", k, 32'd6);
        chk("spur_data", bus.res_data, 32'hAAAA_0001);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        @(negedge clk);
        chk("spur_hold_data", bus.res_data, 32'hAAAA_0001);
        accept();
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (bus.res_valid || fpu_start) ok = 1'b0;
            @(negedge clk);
        end
        chk("spur_one_result", {31'd0, ok}, 32'd1);

        // Reset in the 5th RUN cycle with two requests buffered
        lat = 50;
        send(32'h0000_0001, 32'h0000_0001, 2'b00);
        send(32'h0000_0002, 32'h0000_0002, 2'b00);
        send(32'h0000_0003, 32'h0000_0003, 2'b00);
        chk("mid_run1", {31'd0, fpu_start}, 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_flags", {26'd0, bus.req_ready, bus.res_valid, bus.res_timeout, fpu_rst, fpu_start, busy}, 32'd0);
        chk("mid_rst_fpu_a", fpu_a, 32'd0);
        chk("mid_rst_fpu_b", fpu_b, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel", {30'd0, bus.req_ready, busy}, 32'd2);
        ok = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (bus.res_valid || fpu_start || busy) ok = 1'b0;
            @(negedge clk);
        end
        chk("mid_no_result", {31'd0, ok}, 32'd1);

`ifdef FPU_TIMEOUT_EN
        // FPU never answers: NaN after 16 RUN cycles, then normal operation
        hang = 1'b1;
        send(32'h0000_0BAD, 32'h0000_0001, 2'b01);
        k = 0;
        while (!fpu_start && k < 20) begin @(negedge clk); k++; end
        wait_res("tmo_valid", k);
        chk("tmo_latency", k, 32'd16);
        chk("tmo_data", bus.res_data, 32'h7FC0_0000);
        chk("tmo_flag", {31'd0, bus.res_timeout}, 32'd1);
        accept();
        hang = 1'b0;
        lat  = 4;
        send(32'h0000_1234, 32'h0000_0009, 2'b00);
        wait_res("tmo_next_valid", k);
        chk("tmo_next_data", bus.res_data, 32'h1234_0009);
        chk("tmo_next_flag", {31'd0, bus.res_timeout}, 32'd0);
        accept();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
